// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS subset core: FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB), with memory-wait timeout.
// Optional macro MIPS_SHIFT_EN adds R-type sll/srl.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC     = 32'h0040_0000,
    parameter int          WAIT_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_data_i,
    output logic        dmem_rd_o,
    output logic        dmem_wr_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ready_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [31:0] alu_result_o,
    output logic [2:0]  state_o,
    output logic        halt_o
);
    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        HALT    = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_SLL   = 6'h00;
`ifdef MIPS_SHIFT_EN
    localparam logic [5:0] FN_SRL   = 6'h02;
`endif
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_NOR   = 6'h27;

    state_t      state, next_state;
    logic [31:0] pc, ir, a_reg, b_reg, imm_reg, alu_out, mdr;
    logic [31:0] regs [32];
    logic [31:0] wait_cnt;
    logic [31:0] alu_calc;
    logic [31:0] wb_value;
    logic [4:0]  wb_dest;
    logic [5:0]  opcode, funct;
    logic        supported, wait_expired, branch_taken;

    assign opcode       = ir[31:26];
    assign funct        = ir[5:0];
    assign wb_dest      = (opcode == OP_RTYPE) ? ir[15:11] : ir[20:16];
    assign wb_value     = (opcode == OP_LW) ? mdr : alu_out;
    assign branch_taken = ((opcode == OP_BEQ) && (a_reg == b_reg)) ||
                          ((opcode == OP_BNE) && (a_reg != b_reg));
    // A ready arriving in the last counted cycle wins over the timeout.
    assign wait_expired = (WAIT_TIMEOUT > 0) && (wait_cnt == 32'(WAIT_TIMEOUT - 1));

    assign imem_addr_o  = pc;
    assign dmem_addr_o  = alu_out;
    assign dmem_wdata_o = b_reg;
    assign state_o      = state;
    assign halt_o       = (state == HALT);

    always_comb begin
        supported = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR: supported = 1'b1;
`ifdef MIPS_SHIFT_EN
                    FN_SLL, FN_SRL: supported = 1'b1;
`else
                    FN_SLL: supported = (ir == 32'h0);
`endif
                    default: supported = 1'b0;
                endcase
            end
            OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_LW, OP_SW: supported = 1'b1;
            default: supported = 1'b0;
        endcase
    end

    always_comb begin
        alu_calc = a_reg + imm_reg;
        case (opcode)
            OP_ORI: alu_calc = a_reg | {16'h0000, ir[15:0]};
            OP_RTYPE: begin
                case (funct)
                    FN_SUB:  alu_calc = a_reg - b_reg;
                    FN_AND:  alu_calc = a_reg & b_reg;
                    FN_OR:   alu_calc = a_reg | b_reg;
                    FN_NOR:  alu_calc = ~(a_reg | b_reg);
`ifdef MIPS_SHIFT_EN
                    FN_SLL:  alu_calc = b_reg << ir[10:6];
                    FN_SRL:  alu_calc = b_reg >> ir[10:6];
`endif
                    default: alu_calc = a_reg + b_reg;
                endcase
            end
            default: alu_calc = a_reg + imm_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    // Requests are gated by reset so nothing is issued while reset is held.
    always_comb begin
        next_state = state;
        imem_req_o = 1'b0;
        dmem_rd_o  = 1'b0;
        dmem_wr_o  = 1'b0;
        case (state)
            FETCH: begin
                imem_req_o = !reset;
                if (imem_ready_i)      next_state = DECODE;
                else if (wait_expired) next_state = HALT;
            end
            DECODE: next_state = supported ? EXECUTE : HALT;
            EXECUTE: begin
                case (opcode)
                    OP_LW, OP_SW:        next_state = MEM;
                    OP_J, OP_BEQ, OP_BNE: next_state = FETCH;
                    default:             next_state = WB;
                endcase
            end
            MEM: begin
                dmem_rd_o = !reset && (opcode == OP_LW);
                dmem_wr_o = !reset && (opcode == OP_SW);
                if (dmem_ready_i)      next_state = (opcode == OP_LW) ? WB : FETCH;
                else if (wait_expired) next_state = HALT;
            end
            WB:      next_state = FETCH;
            HALT:    next_state = HALT;
            default: next_state = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_PC;
            ir           <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            imm_reg      <= '0;
            alu_out      <= '0;
            mdr          <= '0;
            alu_result_o <= '0;
            wait_cnt     <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready_i) begin
                        ir       <= imem_data_i;
                        pc       <= pc + 32'd4;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                DECODE: begin
                    a_reg   <= regs[ir[25:21]];
                    b_reg   <= regs[ir[20:16]];
                    imm_reg <= {{16{ir[15]}}, ir[15:0]};
                end
                EXECUTE: begin
                    alu_out <= alu_calc;
                    if (opcode == OP_J) pc <= {pc[31:28], ir[25:0], 2'b00};
                    else if (branch_taken) pc <= pc + (imm_reg << 2);
                end
                MEM: begin
                    if (dmem_ready_i) begin
                        mdr      <= dmem_rdata_i;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                WB: begin
                    // $0 is never written, which keeps it reading as zero.
                    if (wb_dest != 5'd0) begin
                        regs[wb_dest] <= wb_value;
                        alu_result_o  <= wb_value;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: directed scenarios plus a random instruction stream
// checked against an instruction-level model of the MIPS subset.
`timescale 1ns/1ps
module tb_mips_multicycle_core;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam int          TO       = 4;
    localparam int K_BAD = 0, K_WRITE = 1, K_LOAD = 2, K_STORE = 3, K_FLOW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_o, imem_ready_i = 1'b0;
    logic [31:0] imem_addr_o, imem_data_i = '0;
    logic        dmem_rd_o, dmem_wr_o, dmem_ready_i = 1'b0;
    logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i = '0;
    logic [31:0] alu_result_o;
    logic [2:0]  state_o;
    logic        halt_o;

    always #5 clk = ~clk;

    mips_multicycle_core #(.RESET_PC(RESET_PC), .WAIT_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ready_i(imem_ready_i), .imem_data_i(imem_data_i),
        .dmem_rd_o(dmem_rd_o), .dmem_wr_o(dmem_wr_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_ready_i(dmem_ready_i), .dmem_rdata_i(dmem_rdata_i),
        .alu_result_o(alu_result_o), .state_o(state_o), .halt_o(halt_o)
    );

    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_regs [32];
    logic [31:0] m_dmem [16];
    logic [31:0] m_pc, m_alu;
    logic        m_halt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] encR(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sh, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    task automatic doReset();
        reset = 1'b1;
        imem_ready_i = 1'b0;
        dmem_ready_i = 1'b0;
        tick();
        tick();
        checkOutput("rst_state", state_o, 0);
        checkOutput("rst_imem_req", imem_req_o, 0);
        checkOutput("rst_dmem_req", {dmem_rd_o, dmem_wr_o}, 0);
        checkOutput("rst_halt", halt_o, 0);
        checkOutput("rst_alu", alu_result_o, 0);
        checkOutput("rst_pc", imem_addr_o, RESET_PC);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_pc = RESET_PC;
        m_alu = '0;
        m_halt = 1'b0;
        #1;
        checkOutput("rel_imem_req", imem_req_o, 1);
    endtask

    // Instruction-level meaning of one word, evaluated on the model's architectural state.
    task automatic modelDecode(input logic [31:0] instr, output int kind, output logic [4:0] dest,
                               output logic [31:0] value, output logic [31:0] maddr,
                               output logic [31:0] sdata, output logic [31:0] npc);
        logic [31:0] a, b, pc4;
        int simm;
        a = m_regs[instr[25:21]];
        b = m_regs[instr[20:16]];
        simm = $signed(instr[15:0]);
        pc4 = m_pc + 32'd4;
        npc = pc4; kind = K_BAD; dest = '0; value = '0; maddr = '0; sdata = '0;
        case (instr[31:26])
            6'h00: begin
                kind = K_WRITE;
                dest = instr[15:11];
                case (instr[5:0])
                    6'h20: value = a + b;
                    6'h22: value = a - b;
                    6'h24: value = a & b;
                    6'h25: value = a | b;
                    6'h27: value = ~(a | b);
`ifdef MIPS_SHIFT_EN
                    6'h00: value = b << instr[10:6];
                    6'h02: value = b >> instr[10:6];
`else
                    6'h00: if (instr != 32'h0) kind = K_BAD;
`endif
                    default: kind = K_BAD;
                endcase
            end
            6'h08: begin kind = K_WRITE; dest = instr[20:16]; value = a + 32'(simm); end
            6'h0D: begin kind = K_WRITE; dest = instr[20:16]; value = a | {16'h0, instr[15:0]}; end
            6'h23: begin kind = K_LOAD; dest = instr[20:16]; maddr = a + 32'(simm); end
            6'h2B: begin kind = K_STORE; maddr = a + 32'(simm); sdata = b; end
            6'h04: begin kind = K_FLOW; if (a == b) npc = pc4 + 32'(simm * 4); end
            6'h05: begin kind = K_FLOW; if (a != b) npc = pc4 + 32'(simm * 4); end
            6'h02: begin kind = K_FLOW; npc = {pc4[31:28], instr[25:0], 2'b00}; end
            default: kind = K_BAD;
        endcase
    endtask

    // Serve one instruction: fetch ready after idelay stall cycles, data ready after ddelay
    // (ddelay >= TO means the data side never answers), then compare against the model.
    task automatic applyStimulus(input logic [31:0] instr, input int idelay, input int ddelay);
        int kind, cycles, exp_cycles, memk, wr_cycles;
        logic [4:0] dest;
        logic [31:0] value, maddr, sdata, npc;
        logic mem_to;
        modelDecode(instr, kind, dest, value, maddr, sdata, npc);
        mem_to = (kind == K_LOAD || kind == K_STORE) && (ddelay >= TO);
        checkOutput("fetch_addr", imem_addr_o, m_pc);
        checkOutput("fetch_req", imem_req_o, 1);
        cycles = 0;
        for (int k = 0; k <= idelay; k++) begin
            imem_data_i = instr;
            imem_ready_i = (k == idelay);
            tick();
            cycles++;
        end
        imem_ready_i = 1'b0;
        memk = 0;
        wr_cycles = 0;
        while (state_o != 3'd0 && state_o != 3'd5 && cycles < 40) begin
            if (state_o == 3'd3) begin
                checkOutput("mem_rd", dmem_rd_o, (kind == K_LOAD) ? 1 : 0);
                checkOutput("mem_wr", dmem_wr_o, (kind == K_STORE) ? 1 : 0);
                checkOutput("mem_addr", dmem_addr_o, maddr);
                if (kind == K_STORE) checkOutput("mem_wdata", dmem_wdata_o, sdata);
                if (dmem_wr_o) wr_cycles++;
                dmem_ready_i = (memk == ddelay);
                dmem_rdata_i = (memk == ddelay) ? m_dmem[maddr[5:2]] : 32'hDEAD_BEEF;
                memk++;
            end else begin
                dmem_ready_i = 1'b0;
            end
            tick();
            cycles++;
        end
        dmem_ready_i = 1'b0;
        exp_cycles = idelay + 2;
        if (kind != K_BAD) exp_cycles++;
        if (kind == K_LOAD || kind == K_STORE) exp_cycles += mem_to ? TO : ddelay + 1;
        if (kind == K_WRITE || (kind == K_LOAD && !mem_to)) exp_cycles++;
        if (kind == K_STORE) checkOutput("store_wr_cycles", wr_cycles, mem_to ? TO : ddelay + 1);
        m_pc = (kind == K_BAD) ? m_pc + 32'd4 : npc;
        if (kind == K_BAD || mem_to) m_halt = 1'b1;
        if (kind == K_LOAD && !mem_to) value = m_dmem[maddr[5:2]];
        if ((kind == K_WRITE || (kind == K_LOAD && !mem_to)) && dest != 5'd0) begin
            m_regs[dest] = value;
            m_alu = value;
        end
        if (kind == K_STORE && !mem_to) m_dmem[maddr[5:2]] = sdata;
        checkOutput("instr_cycles", cycles, exp_cycles);
        checkOutput("end_state", state_o, m_halt ? 5 : 0);
        checkOutput("end_halt", halt_o, m_halt);
        checkOutput("end_pc", imem_addr_o, m_pc);
        checkOutput("end_alu", alu_result_o, m_alu);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired before the end of the run");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [5:0]  fn_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27};
        logic [31:0] w;
        int n;
        for (int i = 0; i < 16; i++) m_dmem[i] = $urandom;

        // Reset then addi $1,$0,5 with instant memory.
        doReset();
        applyStimulus(encI(6'h08, 5'd0, 5'd1, 16'd5), 0, 0);
        checkOutput("addi5_alu", alu_result_o, 32'd5);
        checkOutput("addi5_pc", imem_addr_o, RESET_PC + 32'd4);

        // Branch at 0x00400010, taken beq then not-taken bne reached via j.
        doReset();
        applyStimulus(encI(6'h08, 5'd0, 5'd1, 16'd7), 0, 0);
        applyStimulus(encI(6'h08, 5'd0, 5'd2, 16'd7), 1, 0);
        applyStimulus(32'h0, 0, 0);
        applyStimulus(32'h0, 2, 0);
        applyStimulus(encI(6'h04, 5'd1, 5'd2, 16'd3), 0, 0);
        checkOutput("beq_target", imem_addr_o, 32'h0040_0020);
        applyStimulus({6'h02, 26'h010_0004}, 0, 0);
        checkOutput("j_target", imem_addr_o, 32'h0040_0010);
        applyStimulus(encI(6'h05, 5'd1, 5'd2, 16'd3), 0, 0);
        checkOutput("bne_fallthru", imem_addr_o, 32'h0040_0014);

        // Store with a slow data port, then load the same word back.
        applyStimulus(encI(6'h2B, 5'd0, 5'd1, 16'd0), 0, 3);
        applyStimulus(encI(6'h23, 5'd0, 5'd3, 16'd0), 0, 1);
        checkOutput("lw_alu", alu_result_o, 32'd7);
        // Fetch ready in the last counted cycle is still accepted.
        applyStimulus(encI(6'h08, 5'd3, 5'd4, 16'hFFFF), TO - 1, 0);

        // Writes to $0 are discarded, then an unsupported opcode halts.
        doReset();
        applyStimulus(encI(6'h08, 5'd0, 5'd0, 16'd9), 0, 0);
        applyStimulus(encR(5'd0, 5'd0, 5'd4, 5'd0, 6'h25), 0, 0);
        checkOutput("zero_alu", alu_result_o, 32'd0);
        applyStimulus(encI(6'h0F, 5'd0, 5'd1, 16'h1234), 0, 0);
        checkOutput("lui_halt", halt_o, 1);
        checkOutput("lui_pc", imem_addr_o, RESET_PC + 32'd12);
        imem_ready_i = 1'b1;
        dmem_ready_i = 1'b1;
        repeat (3) tick();
        checkOutput("halt_absorb_state", state_o, 5);
        checkOutput("halt_absorb_req", {imem_req_o, dmem_rd_o, dmem_wr_o}, 0);

        // Fetch timeout with imem never ready.
        doReset();
        imem_ready_i = 1'b0;
        n = 0;
        while (state_o == 3'd0 && n < TO + 4) begin
            tick();
            n++;
        end
        checkOutput("fetch_to_cycles", n, TO);
        checkOutput("fetch_to_state", state_o, 5);
        checkOutput("fetch_to_halt", halt_o, 1);
        checkOutput("fetch_to_req", imem_req_o, 0);
        doReset();
        checkOutput("after_to_state", state_o, 0);

        // Data-side timeout on a store.
        applyStimulus(encI(6'h2B, 5'd0, 5'd0, 16'd8), 0, TO);

        // Shift: completes with the macro, halts without it.
        doReset();
        applyStimulus(encI(6'h08, 5'd0, 5'd1, 16'd1), 0, 0);
        applyStimulus(encR(5'd0, 5'd1, 5'd5, 5'd31, 6'h00), 0, 0);
`ifdef MIPS_SHIFT_EN
        checkOutput("sll_alu", alu_result_o, 32'h8000_0000);
`else
        checkOutput("sll_halt", halt_o, 1);
`endif

        // Reset in the middle of a store abandons it.
        doReset();
        applyStimulus(encI(6'h08, 5'd0, 5'd1, 16'd7), 0, 0);
        imem_data_i = encI(6'h2B, 5'd0, 5'd1, 16'd4);
        imem_ready_i = 1'b1;
        tick();
        imem_ready_i = 1'b0;
        tick();
        tick();
        checkOutput("mid_state", state_o, 3);
        checkOutput("mid_wr", dmem_wr_o, 1);
        reset = 1'b1;
        tick();
        checkOutput("mid_rst_state", state_o, 0);
        checkOutput("mid_rst_req", {imem_req_o, dmem_rd_o, dmem_wr_o}, 0);
        checkOutput("mid_rst_alu", alu_result_o, 0);
        doReset();

        // Random instruction stream.
        for (int t = 0; t < 150; t++) begin
            case ($urandom_range(0, 8))
                0: w = encI(6'h08, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
                1: w = encI(6'h0D, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom));
                3: w = encI(6'h2B, 5'd0, 5'($urandom_range(0, 7)), 16'(4 * $urandom_range(0, 15)));
                4: w = encI(6'h23, 5'd0, 5'($urandom_range(0, 7)), 16'(4 * $urandom_range(0, 15)));
                5: w = encI(6'h04, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                            16'($urandom_range(0, 8)) - 16'd4);
                6: w = encI(6'h05, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                            16'($urandom_range(0, 8)) - 16'd4);
                7: w = {6'h02, 26'h010_0000 + 26'($urandom_range(0, 63))};
                default: w = encR(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                  5'($urandom_range(0, 7)), 5'd0, fn_tab[$urandom_range(0, 4)]);
            endcase
            applyStimulus(w, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_core.md
MIPS_MULTICYCLE_CORE -- requirements
Module: mips_multicycle_core

Interface
REQ-001 Parameter RESET_PC, default 32'h0040_0000, is the PC value loaded on reset.
REQ-002 Parameter WAIT_TIMEOUT, default 16, is the maximum cycles waiting on a memory ready; 0 disables the timeout.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req_o  output  1  instruction fetch request.
REQ-006 imem_addr_o  output  32  fetch address (current PC).
REQ-007 imem_ready_i  input  1  fetch data valid this cycle.
REQ-008 imem_data_i  input  32  fetched instruction.
REQ-009 dmem_rd_o / dmem_wr_o  output  1 each  data read / write request.
REQ-010 dmem_addr_o  output  32  data address (ALU result).
REQ-011 dmem_wdata_o  output  32  store data (rt value).
REQ-012 dmem_ready_i  input  1  data access complete this cycle.
REQ-013 dmem_rdata_i  input  32  load data.
REQ-014 alu_result_o  output  32  last value written to the register file.
REQ-015 state_o  output  3  current FSM state encoding.
REQ-016 halt_o  output  1  core halted.

Function
REQ-017 FSM states, encoded: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5.
REQ-018 FETCH: imem_req_o=1 and imem_addr_o=PC; on imem_ready_i, latch IR, set PC=PC+4, go to DECODE.
REQ-019 DECODE: read rs/rt into A/B; sign-extend imm[15:0]; always 1 cycle.
REQ-020 EXECUTE: compute ALU result into register ALUOut; 1 cycle; then R-type/addi/ori go to WB, lw/sw go to MEM, beq/bne/j go to FETCH.
REQ-021 Supported operations: add, sub, and, or, nor (R-type); addi (sign-extended imm); ori (zero-extended imm); lw, sw; beq, bne; j.
REQ-022 Arithmetic is 32-bit modulo 2^32; overflow is ignored and never traps.
REQ-023 Branch target = PC+4 + (sign-extended imm << 2); taken when A==B (beq) or A!=B (bne); j target = {PC+4[31:28], IR[25:0], 2'b00}.
REQ-024 MEM: dmem_rd_o (lw) or dmem_wr_o (sw) held with a stable address and data until dmem_ready_i; lw then goes to WB, sw goes to FETCH.
REQ-025 WB: writes rd (R-type), rt (addi/ori) or rt with latched load data (lw); updates alu_result_o in the same edge; then goes to FETCH.
REQ-026 Register $0 always reads 0; writes to $0 are discarded and do not update alu_result_o.
REQ-027 An unsupported opcode or funct detected in DECODE goes to HALT; PC holds the address of the offending instruction plus 4.
REQ-028 Timeout: if WAIT_TIMEOUT>0 and ready is not seen within WAIT_TIMEOUT consecutive cycles in FETCH or MEM, go to HALT; a ready seen in the last counted cycle is accepted.
REQ-029 HALT is absorbing: halt_o=1, with all requests deasserted, until reset.
REQ-030 Request outputs are 0 in every state other than their own.

Reset
REQ-031 When reset is high at a clock edge: PC=RESET_PC, state=FETCH, all 32 registers=0, alu_result_o=0, halt_o=0, timeout counter=0.
REQ-032 Reset mid-access abandons the transaction; requests are low in the cycle after the reset edge only when reset is still asserted.
REQ-033 While reset is held, outputs stay at their reset values and imem_req_o=0.

Configuration
REQ-034 Macro MIPS_SHIFT_EN: when defined, R-type sll/srl (funct 6'h00/6'h02) shift B by shamt IR[10:6], are written to rd, and take 4 cycles through WB; when undefined, these functs are unsupported per REQ-027, except that IR==32'h0 (nop) still completes as a no-write R-type.

Verification
REQ-035 Reset, then imem ready every cycle with addi $1,$0,5 -> after 4 cycles (FETCH..WB) alu_result_o=5, imem_addr_o=RESET_PC+4.
REQ-036 $1=7, $2=7, beq $1,$2,+3 at PC 0x00400010 -> next imem_addr_o=0x00400020; the same with bne -> 0x00400014.
REQ-037 sw $1,0($0) with dmem_ready_i delayed 3 cycles -> dmem_wr_o high for 4 cycles with addr 0 and data 7; then lw $3,0($0) with rdata 7 -> alu_result_o=7.
REQ-038 WAIT_TIMEOUT=4 with imem_ready_i held low -> halt_o=1 and state_o=5 after 4 FETCH cycles; reset returns state_o to 0.
REQ-039 addi $0,$0,9 then or $4,$0,$0 -> alu_result_o stays 0; lui opcode (6'h0F) -> HALT.
REQ-040 With MIPS_SHIFT_EN defined and $1=1, sll $5,$1,31 -> alu_result_o=32'h8000_0000; without the macro the same word -> halt_o=1.
